// File: rtl/s2p.sv
// s2p: serial-to-parallel receiver with one output holding register so the next word assembles while the last waits.
module s2p #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  input  logic         p_ready
);
  localparam int CW = $clog2(N);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d, p_data_q, p_data_d;
  logic          p_valid_q, p_valid_d, last, acc, load;
  always_comb begin
    last      = cnt_q == CW'(N - 1);
    // Only the word-completing bit can stall, and only while the held word is not leaving.
    s_ready   = !last || !p_valid_q || p_ready;
    acc       = s_valid && s_ready;
    load      = acc && last;
    sh_d      = !acc ? sh_q : MSB_FIRST ? {sh_q[N-2:0], s_data} : {s_data, sh_q[N-1:1]};
    cnt_d     = !acc ? cnt_q : last ? '0 : cnt_q + CW'(1);
    p_data_d  = load ? sh_d : p_data_q;
    p_valid_d = load || (p_valid_q && !p_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sh_q      <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
    end
  end
  assign p_data  = p_data_q;
  assign p_valid = p_valid_q;
endmodule
